// File: rtl/mem_port_arbiter.sv
// Arbitrates a single unified memory port between instruction fetch and the MEM stage,
// one outstanding access at a time, with starvation guard, flush dropping and timeout abort.
module mem_port_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int MAX_DM_STREAK  = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   input  logic                if_flush,
   input  logic                dm_req,
   input  logic                dm_we,
   input  logic [DATA_W/8-1:0] dm_be,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [DATA_W-1:0]   dm_wdata,
   output logic                if_valid,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                dm_valid,
   output logic [DATA_W-1:0]   dm_rdata,
   output logic                stall_f,
   output logic                stall_m,
   output logic                bus_err,
   output logic                mem_req,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_valid,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} ArbState;

   ArbState              state;
   logic                 drop;
   logic [3:0]           streak;
   logic [TIMER_W-1:0]   timer;

   logic busy;
   logic memDone;
   logic timeoutHit;
   logic finishNow;
   logic flushNow;
   logic dropNow;
   logic ifWins;
   logic dmWins;

   assign busy       = (state != IDLE);
   assign memDone    = busy && mem_valid && !reset;
   assign timeoutHit = busy && !mem_valid && !reset && (timer == TIMER_LAST);
   assign finishNow  = memDone || timeoutHit;
   assign flushNow   = (state == BUSY_IF) && if_flush;
   // A flush arriving in the completion cycle already makes that response stale.
   assign dropNow    = drop || flushNow;

   assign ifWins = if_req && (!dm_req || (streak == STREAK_MAX));
   assign dmWins = dm_req && !ifWins;

   assign if_valid = (state == BUSY_IF) && finishNow && !dropNow;
   assign dm_valid = (state == BUSY_DM) && finishNow;
   assign if_rdata = ((state == BUSY_IF) && memDone) ? mem_rdata : '0;
   assign dm_rdata = ((state == BUSY_DM) && memDone) ? mem_rdata : '0;
   assign bus_err  = timeoutHit;
   assign stall_f  = !reset && if_req && !if_valid;
   assign stall_m  = !reset && dm_req && !dm_valid;

   // Fetches carry no payload, so they read the whole word with no store data.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         drop      <= 1'b0;
         streak    <= '0;
         timer     <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               timer <= '0;
               drop  <= 1'b0;
               if (dmWins) begin
                  state     <= BUSY_DM;
                  mem_req   <= 1'b1;
                  mem_we    <= dm_we;
                  mem_be    <= dm_be;
                  mem_addr  <= dm_addr;
                  mem_wdata <= dm_wdata;
                  if (!if_req) begin
                     streak <= '0;
                  end else if (streak != STREAK_MAX) begin
                     streak <= streak + 4'd1;
                  end
               end else if (ifWins) begin
                  state     <= BUSY_IF;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_be    <= '1;
                  mem_addr  <= if_addr;
                  mem_wdata <= '0;
                  streak    <= '0;
               end
            end
            default: begin
               if (finishNow) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  drop    <= 1'b0;
               end else begin
                  timer <= timer + TIMER_W'(1);
                  if (flushNow) begin
                     drop <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_mem_port_arbiter;

   localparam int TMO  = 8;
   localparam int MAXS = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ifReq = 1'b0, ifFlush = 1'b0;
   logic [31:0] ifAddr = '0;
   logic        dmReq = 1'b0, dmWe = 1'b0;
   logic [3:0]  dmBe = '0;
   logic [31:0] dmAddr = '0, dmWdata = '0;
   logic        ifValid, dmValid, stallF, stallM, busErr;
   logic [31:0] ifRdata, dmRdata;
   logic        memReq, memWe;
   logic [3:0]  memBe;
   logic [31:0] memAddr, memWdata;
   logic        memValid;
   logic        memValidDrv = 1'b0, autoResp = 1'b0;
   logic [31:0] memRdata = '0;

   int compared = 0;
   int mismatched = 0;
   logic [31:0] grantLog[$];

   assign memValid = memValidDrv | (autoResp & memReq);

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MAX_DM_STREAK(MAXS), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .reset(reset),
      .if_req(ifReq), .if_addr(ifAddr), .if_flush(ifFlush),
      .dm_req(dmReq), .dm_we(dmWe), .dm_be(dmBe), .dm_addr(dmAddr), .dm_wdata(dmWdata),
      .if_valid(ifValid), .if_rdata(ifRdata), .dm_valid(dmValid), .dm_rdata(dmRdata),
      .stall_f(stallF), .stall_m(stallM), .bus_err(busErr),
      .mem_req(memReq), .mem_we(memWe), .mem_be(memBe), .mem_addr(memAddr), .mem_wdata(memWdata),
      .mem_valid(memValid), .mem_rdata(memRdata)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr,
                                input logic dReq, input logic dWe, input logic [3:0] dBe,
                                input logic [31:0] dAddr, input logic [31:0] dWdata);
      ifReq   = iReq;
      ifAddr  = iAddr;
      dmReq   = dReq;
      dmWe    = dWe;
      dmBe    = dBe;
      dmAddr  = dAddr;
      dmWdata = dWdata;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitMemReq();
      for (int i = 0; i < 20; i++) begin
         tick();
         if (memReq === 1'b1) break;
      end
      checkOutput("memReqRise", 32'(memReq), 32'd1);
   endtask

   // Reference model: who owns the port, how long it has been out, whether the fetch went stale.
   int          mOwner = 0;
   int          mAge = 0;
   int          mDmRun = 0;
   bit          mStale = 1'b0;
   bit          mArmed = 1'b0;
   bit          mPayloadKnown = 1'b0;
   logic        mReq = 1'b0, mWe = 1'b0;
   logic [3:0]  mBe = '0;
   logic [31:0] mAddr = '0, mWdata = '0;

   always @(negedge clk) begin
      bit busyNow, done, tmo, swallow, eIfV, eDmV, eErr;
      busyNow = (mOwner != 0);
      done    = busyNow && memValid && !reset;
      tmo     = busyNow && !memValid && !reset && (mAge == TMO - 1);
      swallow = mStale || (mOwner == 1 && ifFlush);
      eIfV    = (mOwner == 1) && (done || tmo) && !swallow;
      eDmV    = (mOwner == 2) && (done || tmo);
      eErr    = tmo;

      if (mArmed) begin
         checkOutput("if_valid", 32'(ifValid), 32'(eIfV));
         checkOutput("dm_valid", 32'(dmValid), 32'(eDmV));
         checkOutput("bus_err", 32'(busErr), 32'(eErr));
         checkOutput("stall_f", 32'(stallF), 32'(!reset && ifReq && !eIfV));
         checkOutput("stall_m", 32'(stallM), 32'(!reset && dmReq && !eDmV));
         if (eIfV) checkOutput("if_rdata", ifRdata, done ? memRdata : 32'd0);
         if (eDmV && !dmWe) checkOutput("dm_rdata", dmRdata, done ? memRdata : 32'd0);
         checkOutput("mem_req", 32'(memReq), 32'(mReq));
         checkOutput("mem_we", 32'(memWe), 32'(mWe));
         checkOutput("mem_addr", memAddr, mAddr);
         if (mPayloadKnown) begin
            checkOutput("mem_be", 32'(memBe), 32'(mBe));
            checkOutput("mem_wdata", memWdata, mWdata);
         end
      end

      if (reset) begin
         mOwner = 0; mAge = 0; mDmRun = 0; mStale = 1'b0;
         mReq = 1'b0; mWe = 1'b0; mBe = '0; mAddr = '0; mWdata = '0;
         mPayloadKnown = 1'b1;
         mArmed = 1'b1;
      end else if (mOwner == 0) begin
         if (dmReq && (!ifReq || mDmRun != MAXS)) begin
            mOwner = 2; mAge = 0; mReq = 1'b1;
            mWe = dmWe; mBe = dmBe; mAddr = dmAddr; mWdata = dmWdata;
            mPayloadKnown = 1'b1;
            mDmRun = ifReq ? ((mDmRun + 1 > MAXS) ? MAXS : mDmRun + 1) : 0;
         end else if (ifReq) begin
            mOwner = 1; mAge = 0; mReq = 1'b1;
            mWe = 1'b0; mAddr = ifAddr;
            mPayloadKnown = 1'b0;
            mDmRun = 0;
         end
      end else if (done || tmo) begin
         mOwner = 0; mReq = 1'b0; mStale = 1'b0;
      end else begin
         mAge++;
         if (mOwner == 1 && ifFlush) mStale = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (!reset && memReq && memValid) grantLog.push_back(memAddr);
   end

   initial begin
      // Reset: request held during reset must not stall.
      ifReq = 1'b1;
      tick();
      tick();
      checkOutput("rstMemReq", 32'(memReq), 32'd0);
      checkOutput("rstMemAddr", memAddr, 32'd0);
      checkOutput("rstMemBe", 32'(memBe), 32'd0);
      checkOutput("rstStallF", 32'(stallF), 32'd0);
      checkOutput("rstIfValid", 32'(ifValid), 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      tick();

      // Fetch only, memory answers 3 cycles after mem_req rises.
      applyStimulus(1, 32'h1000, 0, 0, 0, 0, 0);
      #1 checkOutput("fetchStallIdle", 32'(stallF), 32'd1);
      waitMemReq();
      checkOutput("fetchAddr", memAddr, 32'h1000);
      checkOutput("fetchWe", 32'(memWe), 32'd0);
      tick();
      checkOutput("fetchStallBusy", 32'(stallF), 32'd1);
      tick();
      tick();
      memValidDrv = 1'b1;
      memRdata = 32'h0000_0013;
      #1;
      checkOutput("fetchValid", 32'(ifValid), 32'd1);
      checkOutput("fetchRdata", ifRdata, 32'h13);
      checkOutput("fetchStallDone", 32'(stallF), 32'd0);
      tick();
      memValidDrv = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      tick();

      // Both held with 1-cycle memory: streak guard lets the fetch in after 4 data grants.
      grantLog.delete();
      applyStimulus(1, 32'h2000, 1, 0, 4'hF, 32'h3000, 0);
      autoResp = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (grantLog.size() >= 6) break;
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      autoResp = 1'b0;
      checkOutput("grantCount", 32'(grantLog.size()), 32'd6);
      if (grantLog.size() >= 6) begin
         checkOutput("grant0", grantLog[0], 32'h3000);
         checkOutput("grant1", grantLog[1], 32'h3000);
         checkOutput("grant2", grantLog[2], 32'h3000);
         checkOutput("grant3", grantLog[3], 32'h3000);
         checkOutput("grant4", grantLog[4], 32'h2000);
         checkOutput("grant5", grantLog[5], 32'h3000);
      end
      tick();

      // Store; a flush pulse while the data side owns the port must be ignored.
      applyStimulus(0, 0, 1, 1, 4'b0011, 32'h100, 32'hDEADBEEF);
      waitMemReq();
      checkOutput("storeWe", 32'(memWe), 32'd1);
      checkOutput("storeBe", 32'(memBe), 32'b0011);
      checkOutput("storeAddr", memAddr, 32'h100);
      checkOutput("storeWdata", memWdata, 32'hDEADBEEF);
      ifFlush = 1'b1;
      tick();
      ifFlush = 1'b0;
      memValidDrv = 1'b1;
      #1;
      checkOutput("storeValid", 32'(dmValid), 32'd1);
      checkOutput("storeNoIf", 32'(ifValid), 32'd0);
      tick();
      memValidDrv = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      tick();

      // Flush one cycle into a fetch: stale response swallowed, redirected address granted next.
      applyStimulus(1, 32'h4000, 0, 0, 0, 0, 0);
      waitMemReq();
      tick();
      ifFlush = 1'b1;
      ifAddr = 32'h4400;
      tick();
      ifFlush = 1'b0;
      tick();
      memValidDrv = 1'b1;
      memRdata = 32'h0000_0BAD;
      #1 checkOutput("flushSwallow", 32'(ifValid), 32'd0);
      tick();
      memValidDrv = 1'b0;
      waitMemReq();
      checkOutput("flushNewAddr", memAddr, 32'h4400);
      memValidDrv = 1'b1;
      memRdata = 32'h0000_600D;
      #1;
      checkOutput("flushNewValid", 32'(ifValid), 32'd1);
      checkOutput("flushNewRdata", ifRdata, 32'h600D);
      tick();
      memValidDrv = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      tick();

      // Load with no memory answer: abort in the 8th busy cycle.
      applyStimulus(0, 0, 1, 0, 4'hF, 32'h200, 0);
      memRdata = 32'h55;
      waitMemReq();
      for (int i = 0; i < 6; i++) tick();
      checkOutput("tmoEarlyErr", 32'(busErr), 32'd0);
      tick();
      checkOutput("tmoErr", 32'(busErr), 32'd1);
      checkOutput("tmoDmValid", 32'(dmValid), 32'd1);
      checkOutput("tmoRdata", dmRdata, 32'd0);
      tick();
      checkOutput("tmoMemReqDrop", 32'(memReq), 32'd0);
      checkOutput("tmoErrOnce", 32'(busErr), 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      tick();

      // mem_valid in the timeout cycle wins: normal completion, no error.
      applyStimulus(0, 0, 1, 0, 4'hF, 32'h240, 0);
      waitMemReq();
      for (int i = 0; i < 7; i++) tick();
      memValidDrv = 1'b1;
      memRdata = 32'h77;
      #1;
      checkOutput("raceErr", 32'(busErr), 32'd0);
      checkOutput("raceValid", 32'(dmValid), 32'd1);
      checkOutput("raceRdata", dmRdata, 32'h77);
      tick();
      memValidDrv = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      tick();

      // Reset in the middle of a fetch, followed by a late memory answer.
      applyStimulus(1, 32'h5000, 0, 0, 0, 0, 0);
      waitMemReq();
      tick();
      reset = 1'b1;
      #1 checkOutput("rstMidStall", 32'(stallF), 32'd0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      memValidDrv = 1'b1;
      memRdata = 32'h99;
      #1;
      checkOutput("rstMidMemReq", 32'(memReq), 32'd0);
      checkOutput("rstMidAddr", memAddr, 32'd0);
      checkOutput("rstMidIfValid", 32'(ifValid), 32'd0);
      tick();
      reset = 1'b0;
      #1;
      checkOutput("lateValidIgnored", 32'(ifValid), 32'd0);
      checkOutput("lateValidNoErr", 32'(busErr), 32'd0);
      tick();
      memValidDrv = 1'b0;
      checkOutput("rstIdleMemReq", 32'(memReq), 32'd0);
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
